pe_addsub_lanes: RTL and testbench

Parametrised, multi-lane successor to the single-lane add/sub processing element of the polynomial arithmetic unit. Each lane performs the modular addition, subtraction and halving half of the NTT/INTT butterfly and the coefficient-wise add/sub paths for ML-KEM (q = 3329). All modes share one uniform pipeline latency. A mode tag travels with every beat, and the whole pipe stalls under valid/ready backpressure. The block sits between the AU controller/multiplier outputs and the polynomial memory write-back.

---
 rtl/poly_arith_pkg.sv | 46 ++++
 rtl/pe_addsub_lanes_if.sv | 33 +++
 rtl/pe_addsub_lane.sv | 51 +++++
 rtl/pe_addsub_lanes.sv | 79 +++++++
 tb/tb_pe_addsub_lanes.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_arith_pkg.sv
// Shared types and modular helpers for the ML-KEM polynomial arithmetic unit (q = 3329).
package poly_arith_pkg;

  localparam int unsigned Q           = 3329;
  localparam int unsigned COEFF_WIDTH = 12;
  localparam logic [COEFF_WIDTH:0] Q13 = 13'(Q);

  typedef logic [COEFF_WIDTH-1:0] coeff_t;

  typedef enum logic [2:0] {
    PE_MODE_NTT  = 3'd0,
    PE_MODE_INTT = 3'd1,
    PE_MODE_CWM  = 3'd2,
    PE_MODE_ADD  = 3'd3,
    PE_MODE_SUB  = 3'd4
  } pe_mode_e;

  // Per-lane payload carried by each pipeline stage; the stage record in the
  // top wraps LANES of these together with mode, mask and valid.
  typedef struct packed {
    coeff_t u;
    coeff_t v;
  } pe_pair_t;

  function automatic coeff_t mod_add(coeff_t x, coeff_t y);
    logic [COEFF_WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q13) s = s - Q13;
    return s[COEFF_WIDTH-1:0];
  endfunction

  function automatic coeff_t mod_sub(coeff_t x, coeff_t y);
    logic [COEFF_WIDTH:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + Q13;
    return s[COEFF_WIDTH-1:0];
  endfunction

  function automatic coeff_t mod_half(coeff_t x);
    logic [COEFF_WIDTH:0] s;
    s = {1'b0, x};
    if (x[0]) s = s + Q13;
    return s[COEFF_WIDTH:1];
  endfunction

endpackage

// File: rtl/pe_addsub_lanes_if.sv
// Operand/result bus of the multi-lane add/sub processing element.
interface pe_addsub_lanes_if
  import poly_arith_pkg::*;
#(
  parameter int unsigned LANES = 4
) ();

  logic [LANES*COEFF_WIDTH-1:0] a_i;
  logic [LANES*COEFF_WIDTH-1:0] b_i;
  logic [LANES*COEFF_WIDTH-1:0] c_i;
  pe_mode_e                     mode_i;
  logic [LANES-1:0]             lane_mask_i;
  logic                         valid_i;
  logic                         ready_o;
  logic                         flush_i;
  logic [LANES*COEFF_WIDTH-1:0] u_o;
  logic [LANES*COEFF_WIDTH-1:0] v_o;
  pe_mode_e                     mode_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         busy_o;

  modport master (
    output a_i, b_i, c_i, mode_i, lane_mask_i, valid_i, flush_i, ready_i,
    input  ready_o, u_o, v_o, mode_o, valid_o, busy_o
  );

  modport slave (
    input  a_i, b_i, c_i, mode_i, lane_mask_i, valid_i, flush_i, ready_i,
    output ready_o, u_o, v_o, mode_o, valid_o, busy_o
  );

endinterface

// File: rtl/pe_addsub_lane.sv
// One coefficient lane: raw modular add/sub (feeds stage 1) and halving/masking
// of the registered raw results (feeds stage 2). Purely combinational.
module pe_addsub_lane
  import poly_arith_pkg::*;
(
  input  coeff_t   a_i,
  input  coeff_t   b_i,
  input  coeff_t   c_i,
  input  pe_mode_e mode_i,
  output coeff_t   u_raw_o,
  output coeff_t   v_raw_o,
  input  coeff_t   u_raw_i,
  input  coeff_t   v_raw_i,
  input  pe_mode_e mode_raw_i,
  input  logic     en_i,
  output coeff_t   u_o,
  output coeff_t   v_o
);

  always_comb begin
    u_raw_o = '0;
    v_raw_o = '0;
    case (mode_i)
      PE_MODE_NTT: begin
        u_raw_o = mod_add(a_i, c_i);
        v_raw_o = mod_sub(a_i, c_i);
      end
      PE_MODE_INTT: begin
        u_raw_o = mod_add(a_i, b_i);
        v_raw_o = mod_sub(b_i, a_i);
      end
      PE_MODE_CWM: begin
        u_raw_o = mod_add(a_i, c_i);
        v_raw_o = mod_add(b_i, c_i);
      end
      PE_MODE_ADD: u_raw_o = mod_add(a_i, b_i);
      PE_MODE_SUB: u_raw_o = mod_sub(a_i, b_i);
      default: ;
    endcase
  end

  always_comb begin
    u_o = (mode_raw_i == PE_MODE_INTT) ? mod_half(u_raw_i) : u_raw_i;
    v_o = v_raw_i;
    if (!en_i) begin
      u_o = '0;
      v_o = '0;
    end
  end

endmodule

// File: rtl/pe_addsub_lanes.sv
// Multi-lane modular add/sub/half processing element with a uniform LAT-deep
// pipeline that stalls as a whole under valid/ready backpressure.
module pe_addsub_lanes
  import poly_arith_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned LAT   = 4
) (
  input logic              clk,
  input logic              rst,
  pe_addsub_lanes_if.slave bus
);

  typedef struct packed {
    pe_pair_t [LANES-1:0] res;
    pe_mode_e             mode;
    logic [LANES-1:0]     mask;
    logic                 valid;
  } stage_t;

  stage_t               st_q [LAT];
  stage_t               s1_d;
  stage_t               s2_d;
  pe_pair_t [LANES-1:0] raw;
  pe_pair_t [LANES-1:0] fin;
  logic                 adv;
  logic                 busy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pe_addsub_lane u_lane (
      .a_i       (bus.a_i[k*COEFF_WIDTH +: COEFF_WIDTH]),
      .b_i       (bus.b_i[k*COEFF_WIDTH +: COEFF_WIDTH]),
      .c_i       (bus.c_i[k*COEFF_WIDTH +: COEFF_WIDTH]),
      .mode_i    (bus.mode_i),
      .u_raw_o   (raw[k].u),
      .v_raw_o   (raw[k].v),
      .u_raw_i   (st_q[0].res[k].u),
      .v_raw_i   (st_q[0].res[k].v),
      .mode_raw_i(st_q[0].mode),
      .en_i      (st_q[0].mask[k]),
      .u_o       (fin[k].u),
      .v_o       (fin[k].v)
    );

    assign bus.u_o[k*COEFF_WIDTH +: COEFF_WIDTH] = st_q[LAT-1].res[k].u;
    assign bus.v_o[k*COEFF_WIDTH +: COEFF_WIDTH] = st_q[LAT-1].res[k].v;
  end

  // One global advance: bubbles travel with the pipe rather than collapsing.
  assign adv = !st_q[LAT-1].valid || bus.ready_i;

  always_comb begin
    s1_d = '{res: raw, mode: bus.mode_i, mask: bus.lane_mask_i, valid: bus.valid_i};
    s2_d = '{res: fin, mode: st_q[0].mode, mask: '0, valid: st_q[0].valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) st_q[i] <= '0;
    end else if (bus.flush_i) begin
      for (int unsigned i = 0; i < LAT; i++) st_q[i].valid <= 1'b0;
    end else if (adv) begin
      st_q[0] <= s1_d;
      st_q[1] <= s2_d;
      for (int unsigned i = 2; i < LAT; i++) st_q[i] <= st_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) busy = busy | st_q[i].valid;
  end

  assign bus.ready_o = adv;
  assign bus.valid_o = st_q[LAT-1].valid;
  assign bus.mode_o  = st_q[LAT-1].mode;
  assign bus.busy_o  = busy;

endmodule

// File: tb/tb_pe_addsub_lanes.sv
// Randomized self-checking bench for pe_addsub_lanes against a plain-arithmetic
// reference model with an in-order scoreboard.
module tb_pe_addsub_lanes;
  import poly_arith_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned LAT   = 4;
  localparam int unsigned QM    = 3329;
  localparam int unsigned W     = LANES * 12;

  typedef struct packed {
    logic [2:0]   mode;
    logic [W-1:0] u;
    logic [W-1:0] v;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_addsub_lanes_if #(.LANES(LANES)) bus ();

  pe_addsub_lanes #(.LANES(LANES), .LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t         q[$];
  int           nchk = 0;
  int           nerr = 0;
  int           last_stall = -1;
  bit           accepted = 1'b0;
  bit           exp_stall = 1'b0;
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_u, prev_v;
  logic [2:0]   prev_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int unsigned half_q(int unsigned x);
    return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
  endfunction

  function automatic void model(input int unsigned m, input int unsigned a,
                                input int unsigned b, input int unsigned c,
                                output int unsigned u, output int unsigned v);
    u = 0;
    v = 0;
    case (m)
      0: begin u = (a + c) % QM;          v = (a + QM - c) % QM; end
      1: begin u = half_q((a + b) % QM);  v = (b + QM - a) % QM; end
      2: begin u = (a + c) % QM;          v = (b + c) % QM;      end
      3: u = (a + b) % QM;
      4: u = (a + QM - b) % QM;
      default: ;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*12 +: 12] = 12'($urandom_range(QM - 1));
    return r;
  endfunction

  task automatic push_expected();
    exp_t        e;
    int unsigned u, v;
    e.mode = bus.mode_i;
    e.acc  = cyc + 1;
    for (int k = 0; k < LANES; k++) begin
      model(32'(bus.mode_i), 32'(bus.a_i[k*12 +: 12]), 32'(bus.b_i[k*12 +: 12]),
            32'(bus.c_i[k*12 +: 12]), u, v);
      if (!bus.lane_mask_i[k]) begin
        u = 0;
        v = 0;
      end
      e.u[k*12 +: 12] = 12'(u);
      e.v[k*12 +: 12] = 12'(v);
    end
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (prev_hold) begin
      chk("hold_u", bus.u_o, prev_u);
      chk("hold_v", bus.v_o, prev_v);
      chk("hold_mode", bus.mode_o, prev_mode);
      chk("hold_valid", bus.valid_o, 1'b1);
    end
    if (exp_stall) begin
      chk("stall_ready_o", bus.ready_o, 1'b0);
      chk("stall_valid_o", bus.valid_o, 1'b1);
    end
    if (!bus.ready_i) last_stall = cyc;
    if (bus.valid_o && bus.ready_i) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("u_o", bus.u_o, e.u);
        chk("v_o", bus.v_o, e.v);
        chk("mode_o", bus.mode_o, e.mode);
        if (e.acc > last_stall) chk("latency", cyc, e.acc + int'(LAT) - 1);
      end
    end
    prev_hold = bus.valid_o && !bus.ready_i;
    prev_u    = bus.u_o;
    prev_v    = bus.v_o;
    prev_mode = bus.mode_o;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    accepted = 1'b0;
    if (bus.valid_i && bus.ready_o) begin
      accepted = 1'b1;
      if (!bus.flush_i) push_expected();
    end
    if (bus.flush_i) q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [LANES-1:0] mk,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input bit fl);
    bus.a_i         = a;
    bus.b_i         = b;
    bus.c_i         = c;
    bus.mode_i      = pe_mode_e'(m);
    bus.lane_mask_i = mk;
    bus.valid_i     = 1'b1;
    bus.flush_i     = fl;
    if (fl) begin
      cycle();
    end else begin
      accepted = 1'b0;
      for (int n = 0; n < 20 && !accepted; n++) cycle();
      chk("accept", accepted, 1'b1);
    end
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  task automatic send_rand(input bit any_mask);
    logic [LANES-1:0] mk;
    mk = (any_mask && $urandom_range(3) == 0) ? LANES'($urandom) : '1;
    send(3'($urandom_range(7)), mk, rand_vec(), rand_vec(), rand_vec(), 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < int'(LAT) + 10 && (q.size() != 0 || bus.valid_o); n++) cycle();
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", bus.busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b, c;
    bus.a_i = '0; bus.b_i = '0; bus.c_i = '0;
    bus.mode_i = PE_MODE_NTT; bus.lane_mask_i = '0;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.ready_i = 1'b1;

    #12;
    chk("rst_valid_o", bus.valid_o, 1'b0);
    chk("rst_busy_o", bus.busy_o, 1'b0);
    chk("rst_ready_o", bus.ready_o, 1'b1);
    chk("rst_u_o", bus.u_o, '0);
    chk("rst_v_o", bus.v_o, '0);
    chk("rst_mode_o", bus.mode_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // NTT butterfly with a lane-0 wraparound
    a = rand_vec(); b = rand_vec(); c = rand_vec();
    a[11:0] = 12'd3000; c[11:0] = 12'd500;
    send(3'd0, '1, a, b, c, 1'b0);
    drain();

    // INTT halving of an odd sum, and SUB underflow
    a = rand_vec(); b = rand_vec(); c = rand_vec();
    a[11:0] = 12'd1; b[11:0] = 12'd2;
    send(3'd1, '1, a, b, c, 1'b0);
    a = rand_vec(); b = rand_vec();
    a[11:0] = 12'd5; b[11:0] = 12'd10;
    send(3'd4, '1, a, b, c, 1'b0);
    drain();

    // back-to-back mixed-mode stream
    for (int i = 0; i < 64; i++) send_rand(1'b1);
    drain();

    // 20-beat stream with a 3-cycle downstream stall at beat 6
    for (int i = 0; i < 20; i++) begin
      if (i == 6) begin
        bus.a_i = rand_vec(); bus.b_i = rand_vec(); bus.c_i = rand_vec();
        bus.mode_i = pe_mode_e'(3'($urandom_range(4)));
        bus.lane_mask_i = '1;
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b0;
        exp_stall = 1'b1;
        repeat (3) cycle();
        exp_stall = 1'b0;
        bus.ready_i = 1'b1;
        send(3'(bus.mode_i), '1, bus.a_i, bus.b_i, bus.c_i, 1'b0);
      end else begin
        send_rand(1'b0);
      end
    end
    drain();

    // lane mask 1010
    send(3'd0, 4'b1010, rand_vec(), rand_vec(), rand_vec(), 1'b0);
    send(3'd2, 4'b1010, rand_vec(), rand_vec(), rand_vec(), 1'b0);
    send(3'd1, 4'b1010, rand_vec(), rand_vec(), rand_vec(), 1'b0);
    drain();

    // flush with three beats in flight plus a same-cycle accept
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    send(3'd3, '1, rand_vec(), rand_vec(), rand_vec(), 1'b1);
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      chk("flush_valid_o", bus.valid_o, 1'b0);
      chk("flush_busy_o", bus.busy_o, 1'b0);
      cycle();
    end
    send_rand(1'b0);
    drain();

    // asynchronous reset while stalled mid-stream
    for (int i = 0; i < 5; i++) send_rand(1'b0);
    bus.ready_i = 1'b0;
    repeat (4) cycle();
    #1 rst = 1'b1;
    #1;
    chk("arst_valid_o", bus.valid_o, 1'b0);
    chk("arst_busy_o", bus.busy_o, 1'b0);
    chk("arst_ready_o", bus.ready_o, 1'b1);
    chk("arst_u_o", bus.u_o, '0);
    chk("arst_v_o", bus.v_o, '0);
    chk("arst_mode_o", bus.mode_o, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    prev_hold = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    send(3'd0, '1, rand_vec(), rand_vec(), rand_vec(), 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
